ks_norm_round: RTL
==================

# ks_norm_round

Normalize-and-round back end for the floating-point MAC datapath. It takes the registered Kogge-Stone sum, its carry-out, the operand sign and the pre-normalization exponent, and packs them into an IEEE-754 single-precision word. It applies leading-zero normalization, one-bit right normalization on carry-out, and round-to-nearest-even, with overflow and underflow flags. It is a fixed-latency, 3-stage pipeline with no backpressure, in step with the rest of the MAC pipeline.

## Interface
Parameters: none.
- clock  input  1  single clock, all state rising-edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  qualifies the in_* / Sum / Cout inputs for this cycle
- in_sign  input  1  result sign
- in_exp  input  8  biased exponent for the alignment where M[23] is the hidden one
- Sum  input  24 [24:1]  adder sum bits
- Cout  input  1  adder carry-out
- out_valid  output  1  out_result and flags valid
- out_result  output  32  {sign, exp[7:0], frac[22:0]}
- out_overflow  output  1  result forced to infinity
- out_underflow  output  1  result flushed to zero

## Operation
- Magnitude M[24:0] = {Cout, Sum[24:1]}. Value = M / 2^23 × 2^(in_exp−127).
- Internal exponent e' is 10-bit signed. No sign-extension surprises: in_exp is zero-extended.
- Stage 1 registers M, in_sign, in_exp and in_valid. It also computes k, the position of the leading one in M[23:0], using a 24-bit priority encoder.
- Stage 2 has four cases:
  - M[24]=1: mantissa = M[24:1], guard = M[0], e' = in_exp+1.
  - M[24]=0 and M≠0: mantissa = M[23:0] << (23−k), guard = 0, e' = in_exp−(23−k).
  - M=0: zero flag set.
  - In all cases the stage registers mantissa[23:0], guard, e', sign, zero and valid.
- Stage 3 rounds and packs:
  - RNE with no sticky bit: increment the mantissa iff guard & mantissa[0].
  - If the increment carries out to 2^24: mantissa = 0x800000, e' += 1.
  - Zero flag: out_result = 0x00000000 (+0 regardless of sign). Both flags 0.
  - Else if e' ≤ 0: out_result = {sign, 31'b0}, out_underflow=1. No denormals.
  - Else if e' ≥ 255: out_result = {sign, 8'hFF, 23'b0}, out_overflow=1.
  - Else: out_result = {sign, e'[7:0], mantissa[22:0]}.
- The overflow test runs after the rounding increment.
- Invalid slots still propagate through the pipeline. Their data is don't-care, and out_overflow / out_underflow are forced to 0 when out_valid=0.

## Timing
- Latency is 3 clocks. An input sampled at edge n appears on the outputs after edge n+2, so it is visible in the cycle following edge n+2.
- Throughput is one result per clock. in_valid may be high every cycle, and there is no stall.
- Every output is registered.
- Reset, asynchronous and taking effect immediately:
  - out_valid=0, out_result=0, out_overflow=0, out_underflow=0.
  - All internal valid bits and pipeline registers are cleared to 0.
- Reset asserted mid-stream discards all in-flight items. After resetn rises, out_valid stays 0 until 3 edges after the first valid input.
- No combinational path from inputs to outputs.

## Test plan
- **Unity:** in_exp=127, Cout=0, Sum=24'h800000, sign 0 → 3 cycles later out_valid=1, out_result=0x3F800000, both flags 0.
- **Carry-out normalize + RNE:**
  - Cout=1, Sum=24'h000001, exp=127 → 0x40000000 (tie, even, no round).
  - Sum=24'h000003 → 0x40000002 (tie, odd, round up).
- **Cancellation:**
  - exp=127, Cout=0, Sum=24'h000001 → 0x34000000.
  - All-zero M with sign 1 → 0x00000000, flags 0.
- **Underflow:** exp=10, Sum=24'h000100, sign 1 → 0x80000000, out_underflow=1.
- **Overflow:**
  - exp=254, Cout=1, Sum=0 → 0x7F800000, out_overflow=1.
  - Rounding carry: exp=200, Cout=1, Sum=24'hFFFFFF → 0x65000000, flags 0.
- **Streaming + reset:**
  - Apply 8 back-to-back valid inputs → 8 consecutive correct outputs, in order.
  - Pulse resetn low during the 4th input → out_valid drops in the same cycle. After release, only post-reset inputs emerge.

Source files
------------

// File: rtl/ks_norm_round.sv
// Normalize-and-round back end of the FP MAC: packs {Cout, Sum} with an exponent into an
// IEEE-754 single. Three registered stages: capture + LZ position, normalize, round + pack.
module ks_norm_round (
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:1] Sum,
    input  logic        Cout,
    output logic        out_valid,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow
);

    logic [24:0] m_d;
    logic [4:0]  k_d;

    logic        v1_q, sign1_q;
    logic [7:0]  exp1_q;
    logic [24:0] m1_q;
    logic [4:0]  k1_q;

    logic        v2_q, sign2_q, zero2_q, guard2_q;
    logic [23:0] mant2_q;
    logic signed [9:0] exp2_q;

    logic        zero2_d, guard2_d;
    logic [23:0] mant2_d;
    logic signed [9:0] exp2_d;
    logic [4:0]  shamt;

    logic        round_up, rnd_carry;
    logic [22:0] frac;
    logic signed [9:0] exp_fin;
    logic [31:0] result_d;
    logic        ovf_d, unf_d;

    assign m_d = {Cout, Sum};

    // Leading-one position in M[23:0]; highest set bit wins.
    always_comb begin
        k_d = '0;
        for (int i = 0; i < 24; i++) begin
            if (m_d[i]) k_d = 5'(i);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            exp1_q  <= '0;
            m1_q    <= '0;
            k1_q    <= '0;
        end else begin
            v1_q    <= in_valid;
            sign1_q <= in_sign;
            exp1_q  <= in_exp;
            m1_q    <= m_d;
            k1_q    <= k_d;
        end
    end

    always_comb begin
        shamt    = 5'd23 - k1_q;
        mant2_d  = '0;
        guard2_d = 1'b0;
        zero2_d  = 1'b0;
        exp2_d   = signed'({2'b00, exp1_q});
        if (m1_q[24]) begin
            mant2_d  = m1_q[24:1];
            guard2_d = m1_q[0];
            exp2_d   = signed'({2'b00, exp1_q}) + 10'sd1;
        end else if (|m1_q[23:0]) begin
            mant2_d  = m1_q[23:0] << shamt;
            exp2_d   = signed'({2'b00, exp1_q}) - signed'({5'b00000, shamt});
        end else begin
            zero2_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v2_q     <= 1'b0;
            sign2_q  <= 1'b0;
            zero2_q  <= 1'b0;
            guard2_q <= 1'b0;
            mant2_q  <= '0;
            exp2_q   <= '0;
        end else begin
            v2_q     <= v1_q;
            sign2_q  <= sign1_q;
            zero2_q  <= zero2_d;
            guard2_q <= guard2_d;
            mant2_q  <= mant2_d;
            exp2_q   <= exp2_d;
        end
    end

    // RNE without sticky; an all-ones mantissa wraps its fraction to 0 and bumps the exponent.
    always_comb begin
        round_up  = guard2_q & mant2_q[0];
        rnd_carry = round_up & (&mant2_q);
        frac      = mant2_q[22:0] + 23'(round_up);
        exp_fin   = rnd_carry ? exp2_q + 10'sd1 : exp2_q;
        result_d  = '0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        if (zero2_q) begin
            result_d = '0;
        end else if (exp_fin <= 10'sd0) begin
            result_d = {sign2_q, 31'b0};
            unf_d    = v2_q;
        end else if (exp_fin >= 10'sd255) begin
            result_d = {sign2_q, 8'hFF, 23'b0};
            ovf_d    = v2_q;
        end else begin
            result_d = {sign2_q, exp_fin[7:0], frac};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            out_valid     <= v2_q;
            out_result    <= result_d;
            out_overflow  <= ovf_d;
            out_underflow <= unf_d;
        end
    end

endmodule
